// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle computer I/O controller:
// register offsets, port count and synchroniser priming terminal count.
package sc_io_pkg;

   localparam int NPORT = 4;

   // Byte offsets within I/O space; decode compares against {addr[7:2], 2'b00}.
   localparam logic [7:0] IO_IN0    = 8'h80;
   localparam logic [7:0] IO_IN1    = 8'h84;
   localparam logic [7:0] IO_IN2    = 8'h88;
   localparam logic [7:0] IO_IN3    = 8'h8C;
   localparam logic [7:0] IO_OUT0   = 8'h90;
   localparam logic [7:0] IO_OUT1   = 8'h94;
   localparam logic [7:0] IO_OUT2   = 8'h98;
   localparam logic [7:0] IO_OUT3   = 8'h9C;
   localparam logic [7:0] IO_STATUS = 8'hA0;
   localparam logic [7:0] IO_IRQEN  = 8'hA4;

   // Change detection is armed once the prime counter reaches this value.
   localparam logic [1:0] PRIME_DONE = 2'd3;

endpackage

// File: rtl/sc_io_sync.sv
// Three-stage input synchroniser for one port; s2 is the usable value and
// s2 != s3 flags a change seen on the synchronised side.
module sc_io_sync #(
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] sync_q,
   output logic          changed
);

   logic [DW-1:0] s1;
   logic [DW-1:0] s2;
   logic [DW-1:0] s3;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync_q  = s2;
   assign changed = (s2 != s3);

endmodule

// File: rtl/sc_io_ctrl.sv
// Memory-mapped I/O controller: decodes CPU accesses, holds output ports,
// synchronises inputs and raises an interrupt from sticky change flags.
module sc_io_ctrl
   import sc_io_pkg::*;
#(
   parameter int DW          = 32,
   parameter int IO_BASE_BIT = 7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [31:0]   addr,
   input  logic [DW-1:0] wdata,
   input  logic          we,
   output logic          io_sel,
   output logic [DW-1:0] io_rdata,
   input  logic [DW-1:0] in_port0,
   input  logic [DW-1:0] in_port1,
   input  logic [DW-1:0] in_port2,
   input  logic [DW-1:0] in_port3,
   output logic [DW-1:0] out_port0,
   output logic [DW-1:0] out_port1,
   output logic [DW-1:0] out_port2,
   output logic [DW-1:0] out_port3,
   output logic          irq
);

   logic [DW-1:0]    in_arr  [NPORT];
   logic [DW-1:0]    in_sync [NPORT];
   logic [DW-1:0]    out_q   [NPORT];
   logic [NPORT-1:0] changed;
   logic [NPORT-1:0] status;
   logic [NPORT-1:0] irq_en;
   logic [1:0]       prime_cnt;
   logic [7:0]       off;
   logic             wr;
   logic             det_en;
   logic [NPORT-1:0] set_vec;
   logic [NPORT-1:0] clr_vec;
   logic             unused_addr_bits;

   assign io_sel           = addr[IO_BASE_BIT];
   assign off              = {addr[7:2], 2'b00};
   assign wr               = we & io_sel;
   assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

   assign in_arr[0] = in_port0;
   assign in_arr[1] = in_port1;
   assign in_arr[2] = in_port2;
   assign in_arr[3] = in_port3;

   assign out_port0 = out_q[0];
   assign out_port1 = out_q[1];
   assign out_port2 = out_q[2];
   assign out_port3 = out_q[3];

   for (genvar g = 0; g < NPORT; g++) begin : g_sync
      sc_io_sync #(.DW(DW)) u_sync (
         .clock   (clock),
         .reset   (reset),
         .d       (in_arr[g]),
         .sync_q  (in_sync[g]),
         .changed (changed[g])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPORT; i++) out_q[i] <= '0;
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            if (wr && (off == IO_OUT0 + 8'(4 * i))) out_q[i] <= wdata;
         end
      end
   end

   // Flags stay suppressed while the synchroniser chains fill after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) prime_cnt <= '0;
      else if (prime_cnt != PRIME_DONE) prime_cnt <= prime_cnt + 2'd1;
   end

   assign det_en  = (prime_cnt == PRIME_DONE);
   assign set_vec = changed & {NPORT{det_en}};
   assign clr_vec = (wr && off == IO_STATUS) ? wdata[NPORT-1:0] : '0;

   // Set is OR-ed after the clear mask so a coincident set wins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status <= '0;
         irq_en <= '0;
         irq    <= 1'b0;
      end else begin
         status <= (status & ~clr_vec) | set_vec;
         if (wr && off == IO_IRQEN) irq_en <= wdata[NPORT-1:0];
         irq <= |(status & irq_en);
      end
   end

   always_comb begin
      io_rdata = '0;
      if (io_sel) begin
         case (off)
            IO_IN0:    io_rdata = in_sync[0];
            IO_IN1:    io_rdata = in_sync[1];
            IO_IN2:    io_rdata = in_sync[2];
            IO_IN3:    io_rdata = in_sync[3];
            IO_OUT0:   io_rdata = out_q[0];
            IO_OUT1:   io_rdata = out_q[1];
            IO_OUT2:   io_rdata = out_q[2];
            IO_OUT3:   io_rdata = out_q[3];
            IO_STATUS: io_rdata[NPORT-1:0] = status;
            IO_IRQEN:  io_rdata[NPORT-1:0] = irq_en;
            default:   io_rdata = '0;
         endcase
      end
   end

endmodule
